// File: rtl/vga_rx.sv
// vga_rx: recovers pixel position and colour from a VGA-style stream
// (active-low hs/vs plus 4:4:4 rgb), locking only after two consistent frames.
module vga_rx #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        clr,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_ACT_LO    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_HI    = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_N    = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_LO    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_HI    = 10'(V_SYNC + V_BACK + V_DISP);
  localparam logic [9:0] CNT_MAX     = '1;
  localparam logic [9:0] CNT_PRE     = 10'd1022;

  logic       hs_q, hs_q2, vs_q;
  logic [3:0] r_q, g_q, b_q;
  logic       vs_at_fall;   // vs_q sampled at the most recent hs-fall
  logic       vs_chk;       // armed at vs-start until the first hs-fall with vs high
  logic [9:0] h_cnt, v_cnt;
  state_t     state, state_nxt;

  logic       hs_fall, hs_rise, vs_start, checking;
  logic       h_bad, v_bad, err, fs_nxt;
  logic [9:0] v_cnt_inc;
  logic       in_act;

  // Input capture (q) and second stage (q2) for hs edge detection
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      hs_q  <= 1'b1;
      hs_q2 <= 1'b1;
      vs_q  <= 1'b1;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      hs_q  <= hs;
      hs_q2 <= hs_q;
      vs_q  <= vs;
      r_q   <= r;
      g_q   <= g;
      b_q   <= b;
    end
  end

  // Edge/event decode and timing checks on stage q
  always_comb begin
    hs_fall   = !hs_q && hs_q2;
    hs_rise   = hs_q && !hs_q2;
    vs_start  = hs_fall && !vs_q && vs_at_fall;
    checking  = (state != UNLOCKED);
    v_cnt_inc = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + 10'd1;
    h_bad     = (hs_fall && (h_cnt != H_LAST)) ||
                (hs_rise && (h_cnt != H_SYNC_LAST)) ||
                (!hs_fall && (h_cnt == CNT_PRE));
    v_bad     = (vs_start && (v_cnt != V_LAST)) ||
                (hs_fall && vs_q && vs_chk && (v_cnt_inc != V_SYNC_N));
    err       = checking && (h_bad || v_bad);
  end

  // Line/frame counters and vsync bookkeeping
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      vs_at_fall <= 1'b1;
      vs_chk     <= 1'b0;
    end else begin
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;

      if (vs_start)
        v_cnt <= '0;
      else if (hs_fall)
        v_cnt <= v_cnt_inc;

      if (hs_fall)
        vs_at_fall <= vs_q;

      if (vs_start)
        vs_chk <= 1'b1;
      else if (hs_fall && vs_q)
        vs_chk <= 1'b0;
    end
  end

  // Lock state register
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  // Lock FSM: any error beats a simultaneous vs-start
  always_comb begin
    state_nxt = state;
    fs_nxt    = 1'b0;
    unique case (state)
      UNLOCKED: if (vs_start) state_nxt = ACQUIRE;
      ACQUIRE: begin
        if (err) state_nxt = UNLOCKED;
        else if (vs_start) begin
          state_nxt = LOCKED;
          fs_nxt    = 1'b1;
        end
      end
      LOCKED: begin
        if (err) state_nxt = UNLOCKED;
        else if (vs_start) fs_nxt = 1'b1;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Active-window decode
  always_comb begin
    in_act = (state == LOCKED) &&
             (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
             (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
  end

  // Registered pixel, pulse and status outputs
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      pix_valid   <= in_act;
      pix_x       <= in_act ? 10'(h_cnt - H_ACT_LO) : '0;
      pix_y       <= in_act ? 9'(v_cnt - V_ACT_LO) : '0;
      pix_data    <= in_act ? {r_q, g_q, b_q} : '0;
      frame_start <= fs_nxt;
      h_err       <= checking && h_bad;
      v_err       <= checking && v_bad;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: scaled-timing stream generator with a pixel scoreboard,
// probe-pixel table and hand-built error / reset sequences.
module tb_vga_rx;

  localparam int HS = 4, HB = 6, HD = 16, HT = 32;
  localparam int VS = 2, VB = 3, VD = 24, VT = 32;
  localparam int NP = 6;

  logic        vga_clk = 1'b0;
  logic        clr, hs, vs;
  logic [3:0]  r, g, b;
  logic        pix_valid, frame_start, locked, h_err, v_err;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_data;

  vga_rx #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT)
  ) dut (
    .vga_clk(vga_clk), .clr(clr), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct { int x; int y; int d; int due; } px_t;
  typedef struct { int x; int y; int rgb_in; int exp_d; } probe_t;

  px_t    sb[$];
  probe_t tbl [NP];
  int     hits [NP];
  int     exp_hits [NP];

  int compared = 0, mismatched = 0;
  int pix_n = 0, fs_n = 0, he_n = 0, ve_n = 0;
  int h_err_cyc = -1, v_err_cyc = -1, fs_cyc = -1;
  int lock_rise_cyc = -1, lock_fall_cyc = -1;
  bit prev_locked = 1'b0;
  int frame_cyc, mark_cyc;
  int s_fs, s_he, s_ve, s_pix;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Output monitor: scoreboard pop, idle-zero, probes, event logging
  always @(negedge vga_clk) begin
    if (clr) begin
      prev_locked = 1'b0;
    end else begin
      if (locked && !prev_locked) lock_rise_cyc = cyc;
      if (!locked && prev_locked) lock_fall_cyc = cyc;
      prev_locked = locked;
      if (h_err) begin he_n++; h_err_cyc = cyc; end
      if (v_err) begin ve_n++; v_err_cyc = cyc; end
      if (frame_start) begin fs_n++; fs_cyc = cyc; end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("pix_missing_due", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (pix_valid) begin
        pix_n++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          check("pix_unexpected", 1, 0);
        end else begin
          px_t e;
          e = sb.pop_front();
          check("pix_x", int'(pix_x), e.x);
          check("pix_y", int'(pix_y), e.y);
          check("pix_data", int'(pix_data), e.d);
        end
        for (int i = 0; i < NP; i++)
          if (int'(pix_x) == tbl[i].x && int'(pix_y) == tbl[i].y) begin
            hits[i]++;
            check("probe_data", int'(pix_data), tbl[i].exp_d);
          end
      end else begin
        check("idle_zero", int'(pix_x) + int'(pix_y) + int'(pix_data), 0);
      end
    end
  end

  task automatic drive1(input bit h, input bit v, input logic [11:0] c);
    @(negedge vga_clk);
    hs = h;
    vs = v;
    {r, g, b} = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive1(1'b1, 1'b1, 12'(i));
  endtask

  // One frame; lk marks lines below lock_lines as expected to deliver pixels
  task automatic send_frame(input bit lk, input int vs_lines, input int bad_line,
                            input int bad_len, input int lock_lines, input int mark_line,
                            input int abort_line, input int abort_pos);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : HT;
      for (int p = 0; p < len; p++) begin
        int x, y, c, ti;
        bit act;
        if (l == abort_line && p == abort_pos) return;
        x   = p - (HS + HB) - 1;
        y   = l - (VS + VB);
        c   = int'($urandom_range(0, 4095));
        ti  = -1;
        act = (x >= 0 && x < HD && y >= 0 && y < VD);
        if (act)
          for (int i = 0; i < NP; i++)
            if (tbl[i].x == x && tbl[i].y == y) begin
              c  = tbl[i].rgb_in;
              ti = i;
            end
        drive1(p >= HS, l >= vs_lines, 12'(c));
        if (l == 0 && p == 0) frame_cyc = cyc;
        if (l == mark_line && p == 0) mark_cyc = cyc;
        if (lk && l < lock_lines && act) begin
          sb.push_back('{x: x, y: y, d: c, due: cyc + 2});
          if (ti >= 0) exp_hits[ti]++;
        end
      end
    end
  endtask

  task automatic snap();
    s_fs = fs_n; s_he = he_n; s_ve = ve_n; s_pix = pix_n;
  endtask

  task automatic chk_delta(input string tag, input int fs, input int he, input int ve);
    check({tag, "_frame_start"}, fs_n - s_fs, fs);
    check({tag, "_h_err"}, he_n - s_he, he);
    check({tag, "_v_err"}, ve_n - s_ve, ve);
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_pix_x"}, int'(pix_x), 0);
    check({tag, "_pix_y"}, int'(pix_y), 0);
    check({tag, "_pix_data"}, int'(pix_data), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_h_err"}, int'(h_err), 0);
    check({tag, "_v_err"}, int'(v_err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{x: 10, y: 20, rgb_in: 'hABC, exp_d: 'hABC};
    tbl[1] = '{x: 0,  y: 0,  rgb_in: 'h123, exp_d: 'h123};
    tbl[2] = '{x: 15, y: 23, rgb_in: 'hFED, exp_d: 'hFED};
    tbl[3] = '{x: 5,  y: 7,  rgb_in: 'h000, exp_d: 'h000};
    tbl[4] = '{x: 1,  y: 0,  rgb_in: 'hFFF, exp_d: 'hFFF};
    tbl[5] = '{x: 14, y: 23, rgb_in: 'h5A5, exp_d: 'h5A5};
    for (int i = 0; i < NP; i++) begin hits[i] = 0; exp_hits[i] = 0; end

    clr = 1'b1; hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    repeat (3) @(negedge vga_clk);
    #1 chk_outputs_zero("reset");
    @(negedge vga_clk) clr = 1'b0;
    idle(10);

    // Standard stream: lock at the second vs-start
    snap();
    send_frame(1'b0, VS, -1, 0, VT, -1, -1, 0);
    check("acquire_not_locked", int'(locked), 0);
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    check("lock_rise_cyc", lock_rise_cyc, frame_cyc + 2);
    check("frame_start_cyc", fs_cyc, frame_cyc + 2);
    check("locked_after_2", int'(locked), 1);
    chk_delta("std", 1, 0, 0);
    check("std_pix_count", pix_n - s_pix, HD * VD);
    snap();
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    chk_delta("std2", 1, 0, 0);
    check("std2_pix_count", pix_n - s_pix, HD * VD);

    // One line of H_TOTAL+1 clocks
    snap();
    send_frame(1'b1, VS, 10, HT + 1, 11, 11, -1, 0);
    check("hlong_err_cyc", h_err_cyc, mark_cyc + 2);
    check("hlong_unlock_cyc", lock_fall_cyc, mark_cyc + 2);
    check("hlong_locked", int'(locked), 0);
    chk_delta("hlong", 1, 1, 0);
    snap();
    send_frame(1'b0, VS, -1, 0, VT, -1, -1, 0);
    check("hrelock_acq", int'(locked), 0);
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    check("hrelock_cyc", lock_rise_cyc, frame_cyc + 2);
    chk_delta("hrelock", 1, 0, 0);

    // vs low for one extra line
    snap();
    send_frame(1'b1, VS + 1, -1, 0, VS + 1, VS + 1, -1, 0);
    check("vlong_err_cyc", v_err_cyc, mark_cyc + 2);
    check("vlong_locked", int'(locked), 0);
    chk_delta("vlong", 1, 0, 1);
    send_frame(1'b0, VS, -1, 0, VT, -1, -1, 0);
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    check("vrelock_cyc", lock_rise_cyc, frame_cyc + 2);

    // hs lost: held high long enough to saturate h_cnt
    snap();
    idle(1100);
    chk_delta("hs_lost", 0, 1, 0);
    check("hs_lost_locked", int'(locked), 0);
    check("hs_lost_unlock_cyc", lock_fall_cyc, h_err_cyc);
    send_frame(1'b0, VS, -1, 0, VT, -1, -1, 0);
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    check("lost_relock", int'(locked), 1);

    // clr mid-line while locked
    snap();
    send_frame(1'b1, VS, -1, 0, VT, -1, 12, HS + HB + 5);
    @(negedge vga_clk) clr = 1'b1;
    sb.delete();
    #1 chk_outputs_zero("midrst");
    repeat (3) @(negedge vga_clk);
    chk_delta("midrst", 1, 0, 0);
    @(negedge vga_clk) clr = 1'b0;
    idle(10);
    snap();
    send_frame(1'b0, VS, -1, 0, VT, -1, -1, 0);
    check("postrst_acq", int'(locked), 0);
    send_frame(1'b1, VS, -1, 0, VT, -1, -1, 0);
    check("postrst_lock_cyc", lock_rise_cyc, frame_cyc + 2);
    check("postrst_pix_count", pix_n - s_pix, HD * VD);
    chk_delta("postrst", 1, 0, 0);

    idle(5);
    check("sb_leftover", sb.size(), 0);
    for (int i = 0; i < NP; i++) check("probe_hits", hits[i], exp_hits[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
